// File: rtl/board_if.sv
// board_if: player inputs and board/status outputs of the 3x3 game controller.
interface board_if;
    logic       start;
    logic       move_btn;
    logic       sel_btn;
    logic       timeout;
    logic [8:0] board_j1;
    logic [8:0] board_j2;
    logic [3:0] cursor;
    logic       turn;
    logic [1:0] result;
    logic       turn_done;
    logic [1:0] state;
    modport master (
        output start, move_btn, sel_btn, timeout,
        input  board_j1, board_j2, cursor, turn, result, turn_done, state
    );
    modport slave (
        input  start, move_btn, sel_btn, timeout,
        output board_j1, board_j2, cursor, turn, result, turn_done, state
    );
endinterface

// File: rtl/board_controller.sv
// board_controller: 3x3 two-player game logic (cursor, marks, win/draw, turn timeout).
// Define AUTO_MOVE_EN to make a timeout place the mover's mark in the lowest free cell.
module board_controller #(
    parameter bit         FIRST_PLAYER = 1'b0,
    parameter logic [3:0] CURSOR_HOME  = 4'd0
) (
    input logic   clk,
    input logic   rst,
    board_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] PLAY  = 2'b01;
    localparam logic [1:0] CHECK = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;
    // Eight winning lines packed 9 bits each: rows, columns, diagonals.
    localparam logic [71:0] LINES = {9'h007, 9'h038, 9'h1C0, 9'h049,
                                     9'h092, 9'h124, 9'h111, 9'h054};
    logic [8:0] bj1_q, bj1_d, bj2_q, bj2_d;
    logic [3:0] cursor_q, cursor_d;
    logic       turn_q, turn_d, turn_done_q, turn_done_d;
    logic [1:0] result_q, result_d, state_q, state_d;
    logic       start_p_q, move_p_q, sel_p_q;
    logic       start_e, move_e, sel_e, win;
    logic [8:0] occ, cur_bit, mover, mark;
`ifdef AUTO_MOVE_EN
    logic [8:0] low_free;
`endif
    assign start_e = bus.start & ~start_p_q;
    assign move_e  = bus.move_btn & ~move_p_q;
    assign sel_e   = bus.sel_btn & ~sel_p_q;
    always_comb begin
        occ         = bj1_q | bj2_q;
        cur_bit     = 9'd1 << cursor_q;
        mover       = turn_q ? bj2_q : bj1_q;
`ifdef AUTO_MOVE_EN
        low_free    = ~occ & (occ + 9'd1);
`endif
        win         = 1'b0;
        for (int i = 0; i < 8; i++)
            win = win | ((mover & LINES[i*9 +: 9]) == LINES[i*9 +: 9]);
        mark        = 9'd0;
        cursor_d    = cursor_q;
        turn_d      = turn_q;
        turn_done_d = 1'b0;
        result_d    = result_q;
        state_d     = state_q;
        if (start_e) begin
            cursor_d = CURSOR_HOME;
            turn_d   = FIRST_PLAYER;
            result_d = 2'b00;
            state_d  = PLAY;
        end else if (state_q == PLAY) begin
            if (sel_e && !(|(occ & cur_bit))) begin
                mark    = cur_bit;
                state_d = CHECK;
            end else if (bus.timeout) begin
`ifdef AUTO_MOVE_EN
                mark    = low_free;
                state_d = CHECK;
`else
                turn_d      = ~turn_q;
                turn_done_d = 1'b1;
`endif
            end else if (move_e) begin
                cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
            end
        end else if (state_q == CHECK) begin
            if (win) begin
                result_d = turn_q ? 2'b10 : 2'b01;
                state_d  = DONE;
            end else if (&occ) begin
                result_d = 2'b11;
                state_d  = DONE;
            end else begin
                turn_d      = ~turn_q;
                turn_done_d = 1'b1;
                state_d     = PLAY;
            end
        end
        bj1_d = start_e ? 9'd0 : bj1_q | (turn_q ? 9'd0 : mark);
        bj2_d = start_e ? 9'd0 : bj2_q | (turn_q ? mark : 9'd0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bj1_q       <= 9'd0;
            bj2_q       <= 9'd0;
            cursor_q    <= CURSOR_HOME;
            turn_q      <= FIRST_PLAYER;
            turn_done_q <= 1'b0;
            result_q    <= 2'b00;
            state_q     <= IDLE;
            start_p_q   <= 1'b0;
            move_p_q    <= 1'b0;
            sel_p_q     <= 1'b0;
        end else begin
            bj1_q       <= bj1_d;
            bj2_q       <= bj2_d;
            cursor_q    <= cursor_d;
            turn_q      <= turn_d;
            turn_done_q <= turn_done_d;
            result_q    <= result_d;
            state_q     <= state_d;
            start_p_q   <= bus.start;
            move_p_q    <= bus.move_btn;
            sel_p_q     <= bus.sel_btn;
        end
    end
    assign bus.board_j1  = bj1_q;
    assign bus.board_j2  = bj2_q;
    assign bus.cursor    = cursor_q;
    assign bus.turn      = turn_q;
    assign bus.result    = result_q;
    assign bus.turn_done = turn_done_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: directed game sequences against a queue of expected board snapshots.
module tb_board_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    board_if bus();
    board_controller dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        string      tag;
        logic [8:0] j1, j2;
        logic [3:0] cur;
        logic       turn;
        logic [1:0] res, st;
        int         td;
    } exp_t;
    exp_t sb[$];
    int compared = 0, mismatched = 0, td_cnt = 0, td_base = 0, cur_m = 0;
    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.turn_done === 1'b1) td_cnt++;
        cmp("invariant", {23'd0, bus.board_j1 & bus.board_j2}, 32'd0);
    end
    task automatic want(input string tag, input logic [8:0] j1, input logic [8:0] j2,
                        input logic [3:0] cur, input logic t, input logic [1:0] r,
                        input logic [1:0] s, input int td);
        sb.push_back('{tag, j1, j2, cur, t, r, s, td});
    endtask
    task automatic check();
        exp_t e;
        @(negedge clk);
        #1;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            cmp({e.tag, "/board_j1"}, {23'd0, bus.board_j1}, {23'd0, e.j1});
            cmp({e.tag, "/board_j2"}, {23'd0, bus.board_j2}, {23'd0, e.j2});
            cmp({e.tag, "/cursor"}, {28'd0, bus.cursor}, {28'd0, e.cur});
            cmp({e.tag, "/turn"}, {31'd0, bus.turn}, {31'd0, e.turn});
            cmp({e.tag, "/result"}, {30'd0, bus.result}, {30'd0, e.res});
            cmp({e.tag, "/state"}, {30'd0, bus.state}, {30'd0, e.st});
            cmp({e.tag, "/turn_done_count"}, td_cnt - td_base, e.td);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic press(input logic s, input logic m, input logic sl, input logic t);
        bus.start = s; bus.move_btn = m; bus.sel_btn = sl; bus.timeout = t;
        @(posedge clk);
        #1;
        bus.start = 0; bus.move_btn = 0; bus.sel_btn = 0; bus.timeout = 0;
        @(posedge clk);
        #1;
    endtask
    task automatic mv(input int n);
        repeat (n) begin
            press(0, 1, 0, 0);
            cur_m = (cur_m == 8) ? 0 : cur_m + 1;
        end
    endtask
    task automatic place(input int t);
        while (cur_m != t) mv(1);
        press(0, 0, 1, 0);
    endtask
    task automatic new_game();
        td_base = td_cnt;
        press(1, 0, 0, 0);
        cur_m = 0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 0; bus.move_btn = 0; bus.sel_btn = 0; bus.timeout = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        want("reset", 9'h000, 9'h000, 4'd0, 0, 2'b00, 2'b00, 0);
        check();
        cmp("reset/turn_done", {31'd0, bus.turn_done}, 32'd0);
        want("idle_ignore", 9'h000, 9'h000, 4'd0, 0, 2'b00, 2'b00, 0);
        press(0, 1, 1, 1);
        check();
        want("start", 9'h000, 9'h000, 4'd0, 0, 2'b00, 2'b01, 0);
        new_game();
        check();
        want("j1@0", 9'h001, 9'h000, 4'd0, 1, 2'b00, 2'b01, 1);
        place(0);
        check();
        want("j2@1", 9'h001, 9'h002, 4'd1, 0, 2'b00, 2'b01, 2);
        place(1);
        check();
        place(3);
        place(4);
        want("j1_win", 9'h049, 9'h012, 4'd6, 0, 2'b01, 2'b11, 4);
        place(6);
        check();
        want("done_hold", 9'h049, 9'h012, 4'd6, 0, 2'b01, 2'b11, 4);
        press(0, 1, 1, 1);
        check();
        want("restart", 9'h000, 9'h000, 4'd0, 0, 2'b00, 2'b01, 0);
        new_game();
        check();
        place(0); place(1); place(2); place(4);
        place(3); place(5); place(7); place(6);
        want("draw", 9'h18D, 9'h072, 4'd8, 0, 2'b11, 2'b11, 8);
        place(8);
        check();
        new_game();
        place(0);
        place(1);
        want("occ_sel", 9'h001, 9'h002, 4'd1, 0, 2'b00, 2'b01, 2);
        press(0, 0, 1, 0);
        check();
        want("occ_sel_move", 9'h001, 9'h002, 4'd2, 0, 2'b00, 2'b01, 2);
        press(0, 1, 1, 0);
        cur_m = 2;
        check();
        mv(6);
        want("wrap", 9'h001, 9'h002, 4'd8, 0, 2'b00, 2'b01, 2);
        mv(9);
        check();
`ifdef AUTO_MOVE_EN
        want("timeout", 9'h005, 9'h002, 4'd8, 1, 2'b00, 2'b01, 3);
        press(0, 0, 0, 1);
        check();
        want("sel_timeout", 9'h005, 9'h102, 4'd8, 0, 2'b00, 2'b01, 4);
`else
        want("timeout", 9'h001, 9'h002, 4'd8, 1, 2'b00, 2'b01, 3);
        press(0, 0, 0, 1);
        check();
        want("sel_timeout", 9'h001, 9'h102, 4'd8, 0, 2'b00, 2'b01, 4);
`endif
        press(0, 0, 1, 1);
        check();
        td_base = td_cnt;
        want("mid_rst", 9'h000, 9'h000, 4'd0, 0, 2'b00, 2'b00, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check();
        cmp("mid_rst/turn_done", {31'd0, bus.turn_done}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
